// File: rtl/sm_pkg.sv
// Shared definitions for the serial sign-magnitude adder: default width,
// FSM state encoding and sign/magnitude field helpers.
package sm_pkg;

  // Default total operand width (sign bit plus magnitude).
  localparam int SM_WIDTH_DEF = 8;

  // Widest operand the field helpers accept; callers zero-extend into it.
  localparam int SM_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } sm_state_t;

  // Sign field of an n-bit sign-magnitude value (MSB, 1 = negative).
  function automatic logic sm_sign(input logic [SM_MAX_W-1:0] v, input int n);
    logic [SM_MAX_W-1:0] sh;
    sh = v >> (n - 1);
    return sh[0];
  endfunction

  // Magnitude field of an n-bit sign-magnitude value (bits n-2:0).
  function automatic logic [SM_MAX_W-1:0] sm_mag(input logic [SM_MAX_W-1:0] v, input int n);
    logic [SM_MAX_W-1:0] mask;
    mask = (SM_MAX_W'(1) << (n - 1)) - SM_MAX_W'(1);
    return v & mask;
  endfunction

endpackage

// File: rtl/sm_serial_cell.sv
// One-bit full adder / full subtractor used as the bit-serial ALU.
// sub = 0: s = a + b + cin, cout = carry.
// sub = 1: s = a - b - cin, cout = borrow.
module sm_serial_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic sub,
  output logic s,
  output logic cout
);

  // Sum/difference bit is identical for both operations.
  assign s = a ^ b ^ cin;

  // Carry for add, borrow for subtract.
  assign cout = sub ? ((~a & b) | (~(a ^ b) & cin))
                    : ((a & b) | ((a ^ b) & cin));

endmodule

// File: rtl/serial_sm_adder.sv
// Bit-serial sign-magnitude adder. Operands are reordered at capture so the
// larger magnitude is always the minuend, then N-1 magnitude bits are
// processed LSB first through a single sm_serial_cell.
// Optional build macro: SM_ADDER_SAT_EN (saturate the magnitude on add
// overflow instead of truncating it).
module serial_sm_adder
  import sm_pkg::*;
#(
  parameter int N = SM_WIDTH_DEF
) (
  input  logic         in_clk,
  input  logic         in_rst_n,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_valid,
  output logic         o_ready,
  output logic [N-1:0] o_out,
  output logic         o_carry,
  output logic         o_valid,
  input  logic         in_ready
);

  localparam int M  = N - 1;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 2);

  sm_state_t     state_reg;
  sm_state_t     state_next;
  logic          ready_reg;

  logic [M-1:0]  x_reg;
  logic [M-1:0]  y_reg;
  logic [M-1:0]  res_reg;
  logic [CW-1:0] cnt_reg;
  logic          cy_reg;
  logic          sub_reg;
  logic          sign_reg;
  logic [N-1:0]  out_reg;
  logic          carry_reg;

  logic          sign_a;
  logic          sign_b;
  logic [M-1:0]  mag_a;
  logic [M-1:0]  mag_b;
  logic          a_ge_b;
  logic          accept;
  logic          last_bit;

  logic          cell_s;
  logic          cell_cout;

  logic [M-1:0]  fin_mag;
  logic          fin_sign;
  logic          ovf;

  // Field extraction; a -0 operand simply has magnitude 0.
  assign sign_a = sm_sign(SM_MAX_W'(in_a), N);
  assign sign_b = sm_sign(SM_MAX_W'(in_b), N);
  assign mag_a  = M'(sm_mag(SM_MAX_W'(in_a), N));
  assign mag_b  = M'(sm_mag(SM_MAX_W'(in_b), N));
  assign a_ge_b = (mag_a >= mag_b);

  // ready_reg is only ever set while in IDLE, and it stays low for the
  // first cycle after reset release so no operand is taken before o_ready.
  assign accept   = (state_reg == ST_IDLE) && ready_reg && in_valid;
  assign last_bit = (cnt_reg == LAST_BIT);

  sm_serial_cell u_cell (
    .a    (x_reg[0]),
    .b    (y_reg[0]),
    .cin  (cy_reg),
    .sub  (sub_reg),
    .s    (cell_s),
    .cout (cell_cout)
  );

  // Next-state logic for IDLE -> CALC -> DONE -> IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept)   state_next = ST_CALC;
      ST_CALC: if (last_bit) state_next = ST_DONE;
      ST_DONE: if (in_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register and registered ready flag.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_reg <= ST_IDLE;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_next == ST_IDLE);
    end
  end

  // Final result assembled from the last serial bit and the shift register.
  always_comb begin
    fin_mag  = {cell_s, res_reg[M-1:1]};
    ovf      = ~sub_reg & cell_cout;
`ifdef SM_ADDER_SAT_EN
    if (ovf) fin_mag = '1;
`endif
    fin_sign = sign_reg;
    if (!ovf && (fin_mag == '0)) fin_sign = 1'b0;
  end

  // Operand capture and one magnitude bit per CALC cycle, LSB first.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      x_reg    <= '0;
      y_reg    <= '0;
      res_reg  <= '0;
      cnt_reg  <= '0;
      cy_reg   <= 1'b0;
      sub_reg  <= 1'b0;
      sign_reg <= 1'b0;
    end else if (accept) begin
      x_reg    <= a_ge_b ? mag_a : mag_b;
      y_reg    <= a_ge_b ? mag_b : mag_a;
      res_reg  <= '0;
      cnt_reg  <= '0;
      cy_reg   <= 1'b0;
      sub_reg  <= sign_a ^ sign_b;
      sign_reg <= a_ge_b ? sign_a : sign_b;
    end else if (state_reg == ST_CALC) begin
      x_reg   <= x_reg >> 1;
      y_reg   <= y_reg >> 1;
      res_reg <= {cell_s, res_reg[M-1:1]};
      cy_reg  <= cell_cout;
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Output registers load only when an operation completes; they hold
  // their value through IDLE and the next CALC.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_reg   <= '0;
      carry_reg <= 1'b0;
    end else if ((state_reg == ST_CALC) && last_bit) begin
      out_reg   <= {fin_sign, fin_mag};
      carry_reg <= ovf;
    end
  end

  assign o_ready = ready_reg;
  assign o_valid = (state_reg == ST_DONE);
  assign o_out   = out_reg;
  assign o_carry = carry_reg;

endmodule
